// File: rtl/irq_sequencer_if.sv
// Bus between the interrupt sequencer and the program sequencer / CPU control.
// The master drives requests and instruction status, and the slave returns forced fetches and status.
interface irq_sequencer_if #(
  parameter int NUM_IRQ = 4,
  parameter int ADDR_W  = 8
);
  logic [NUM_IRQ-1:0] irq;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_din;
  logic               ie_set;
  logic               ie_clr;
  logic               hold_in;
  logic               reti;
  logic [ADDR_W-1:0]  pc;
  logic               force_jmp;
  logic [ADDR_W-1:0]  force_addr;
  logic [NUM_IRQ-1:0] irq_ack;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic               ie;
  logic               in_service;
  logic [1:0]         active_id;

  modport master (
    output irq, mask_we, mask_din, ie_set, ie_clr, hold_in, reti, pc,
    input  force_jmp, force_addr, irq_ack, pending, mask, ie, in_service, active_id
  );

  modport slave (
    input  irq, mask_we, mask_din, ie_set, ie_clr, hold_in, reti, pc,
    output force_jmp, force_addr, irq_ack, pending, mask, ie, in_service, active_id
  );
endinterface

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: captures request edges and picks the lowest-index source.
// It forces vector entry at a safe instruction boundary and forces the return on reti.
module irq_sequencer #(
  parameter int         NUM_IRQ  = 4,
  parameter int         ADDR_W   = 8,
  parameter logic [3:0] VEC_BASE = 4'hC
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           sync_reset,
  irq_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ENTER, SERVICE, EXIT} state_t;

  state_t             state, state_next;
  logic [NUM_IRQ-1:0] irq_prev, pending, mask, eligible, rise, ack;
  logic               ie;
  logic [ADDR_W-1:0]  ret_addr;
  logic [1:0]         active_id, winner;
  logic [3:0]         vec_hi;
  logic               take_irq, entering;
  logic               force_jmp_c, in_service_c;
  logic [ADDR_W-1:0]  force_addr_c;

  assign rise     = bus.irq & ~irq_prev;
  assign eligible = pending & mask;
  assign vec_hi   = VEC_BASE + {2'b00, active_id};
  assign take_irq = (state == IDLE) && ie && (|eligible);
  assign entering = (state == ENTER) && !bus.hold_in;

  // Scanning downward lets the lowest eligible index overwrite higher ones.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 2'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (sync_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    force_jmp_c  = 1'b0;
    force_addr_c = '0;
    ack          = '0;
    in_service_c = 1'b0;
    case (state)
      IDLE: begin
        if (take_irq) state_next = ENTER;
      end
      ENTER: begin
        if (!bus.hold_in) begin
          force_jmp_c  = 1'b1;
          force_addr_c = ADDR_W'({vec_hi, 4'h0});
          ack          = NUM_IRQ'(1) << active_id;
          state_next   = SERVICE;
        end
      end
      SERVICE: begin
        in_service_c = 1'b1;
        if (bus.reti) state_next = EXIT;
      end
      EXIT: begin
        force_jmp_c  = 1'b1;
        force_addr_c = ret_addr;
        in_service_c = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A new edge on a source beats its own acknowledge in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_prev  <= '0;
      pending   <= '0;
      mask      <= '0;
      ie        <= 1'b0;
      ret_addr  <= '0;
      active_id <= '0;
    end else begin
      irq_prev <= bus.irq;
      if (bus.mask_we) mask <= bus.mask_din;
      if (bus.ie_clr) begin
        ie <= 1'b0;
      end else if (bus.ie_set) begin
        ie <= 1'b1;
      end
      if (sync_reset) begin
        pending  <= '0;
        ret_addr <= '0;
      end else begin
        pending <= (pending & ~ack) | rise;
        if (entering) ret_addr <= bus.pc + ADDR_W'(1);
        if (take_irq) active_id <= winner;
      end
    end
  end

  assign bus.force_jmp  = force_jmp_c;
  assign bus.force_addr = force_addr_c;
  assign bus.irq_ack    = ack;
  assign bus.pending    = pending;
  assign bus.mask       = mask;
  assign bus.ie         = ie;
  assign bus.in_service = in_service_c;
  assign bus.active_id  = active_id;

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Interrupt controller that schedules the program sequencer between the main program and up to NUM_IRQ interrupt handlers.
- Captures request edges, arbitrates by fixed priority, and forces a one-cycle jump to a per-source vector at a safe instruction boundary.
- Saves the return address and forces the jump back when the handler executes a return-from-interrupt.
- Sits beside the program sequencer; its force_jmp/force_addr outputs have highest priority in the sequencer's pm_addr mux, below sync_reset.

Parameters:
NUM_IRQ, 4, number of request lines (1..4)
ADDR_W, 8, program memory address width
VEC_BASE, 4'hC, upper nibble of vector for source 0; source i vectors to {VEC_BASE+i, 4'h0}; VEC_BASE+NUM_IRQ-1 must be <= 4'hF

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
sync_reset  in  1  synchronous reset, shared with the program sequencer
irq  in  NUM_IRQ  level request lines, already synchronous to clk
mask_we  in  1  load mask register from mask_din
mask_din  in  NUM_IRQ  1 = source enabled
ie_set  in  1  set global interrupt enable
ie_clr  in  1  clear global interrupt enable
hold_in  in  1  current instruction is a jump/jmp_nz/return; entry must be deferred
reti  in  1  decoded return-from-interrupt instruction at pc
pc  in  ADDR_W  current program counter from the sequencer
force_jmp  out  1  sequencer must load force_addr into pm_addr this cycle
force_addr  out  ADDR_W  forced fetch address
irq_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge of the source being entered
pending  out  NUM_IRQ  latched pending requests
mask  out  NUM_IRQ  mask register
ie  out  1  global enable
in_service  out  1  high while a handler runs
active_id  out  2  index of the winning/serviced source

Behaviour:
- reset_n low (async): state IDLE; pending, mask, ie, ret_addr, active_id, irq_prev = 0. All outputs are 0.
- sync_reset high (sync, highest priority at the edge): state IDLE, pending = 0, ret_addr = 0. mask and ie are retained.
- Edge capture: irq_prev <= irq. pending[i] sets when irq[i] & ~irq_prev[i]. It clears on ack of source i. If set and clear coincide, set wins.
- Mask: mask <= mask_din when mask_we. ie: ie_set sets it; ie_clr clears it; if both are high, clear wins.
- Eligible = pending & mask. Winner = lowest eligible index.
- FSM states: IDLE, ENTER, SERVICE, EXIT.
- IDLE -> ENTER when ie & |eligible. active_id <= winner at that edge.
- ENTER:
  - force_jmp = ~hold_in. force_addr = {VEC_BASE+active_id, 4'h0}.
  - irq_ack[active_id] = ~hold_in (combinational).
  - When ~hold_in: ret_addr <= pc+1 (mod 2^ADDR_W), pending[active_id] cleared, -> SERVICE.
  - When hold_in: remain in ENTER, no force, no ack. The winner is not re-arbitrated. Masking or ie_clr during ENTER does not cancel entry.
- SERVICE: in_service = 1. -> EXIT when reti. New edges keep setting pending (no nesting).
- EXIT: force_jmp = 1, force_addr = ret_addr, in_service = 1 for exactly one cycle, then -> IDLE. The earliest re-entry is the cycle after IDLE.
- in_service is 0 in IDLE and ENTER.
- force_addr = 0 whenever force_jmp = 0.
- Latency: irq rising edge at cycle n -> pending at n+1 -> ENTER at n+2 -> force_jmp asserted during n+2, given hold_in = 0.
- reti outside SERVICE is ignored.

Test Plan:
- Reset/idle: assert reset_n low mid-SERVICE -> all outputs 0 immediately. After release with ie=0 and irq pulses, pending latches but force_jmp is never asserted.
- Basic entry/exit: mask=4'hF, ie=1, pc=8'h23, irq[1] rises -> two cycles later force_jmp=1, force_addr=8'hD0, irq_ack=4'b0010, pending[1] cleared. After reti -> one-cycle force_jmp with force_addr=8'h24, then IDLE.
- Priority: irq[3] and irq[2] rise in the same cycle -> force_addr=8'hE0, active_id=2, pending=4'b1000. After reti+EXIT, re-enter with force_addr=8'hF0.
- Deferral: hold_in=1 for 3 cycles in ENTER -> no force and no ack for 3 cycles. Entry occurs on the first cycle hold_in=0, and ret_addr = pc of that cycle + 1.
- Wrap and masking: pc=8'hFF at entry -> return force_addr=8'h00. With mask[0]=0, an irq[0] edge stays pending and is never acked until the mask is written 1, after which entry follows.
- sync_reset during SERVICE -> IDLE next cycle, pending=0, mask/ie unchanged, no EXIT force.
